video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/vtg_pkg.sv | 34 +++
 rtl/vtg_if.sv | 27 ++
 rtl/vtg_axis_cnt.sv | 42 ++++
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 tb/tb_video_timing_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vtg_pkg.sv
// Shared timing defaults and helper functions for the video timing generator.
package vtg_pkg;

    localparam int unsigned DEF_H_ACTIVE = 288;
    localparam int unsigned DEF_H_FP     = 22;
    localparam int unsigned DEF_H_SYNC   = 32;
    localparam int unsigned DEF_H_BP     = 42;
    localparam int unsigned DEF_V_ACTIVE = 224;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 7;
    localparam int unsigned DEF_V_BP     = 29;
    localparam int unsigned DEF_CNT_W    = 9;
    localparam int unsigned DEF_RGB_W    = 12;

    function automatic int unsigned vtg_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Nominal sync start shifted by offset, kept inside the blanking interval.
    function automatic int unsigned vtg_sync_start(input int unsigned active, input int unsigned fp,
                                                   input int unsigned sync, input int unsigned total,
                                                   input int offset);
        int s;
        s = int'(active + fp) + offset;
        if (s < int'(active)) begin
            s = int'(active);
        end else if (s > int'(total - sync)) begin
            s = int'(total - sync);
        end
        return s;
    endfunction

endpackage

// File: rtl/vtg_if.sv
// Video output bundle between the timing generator and the pixel source/sink.
interface vtg_if #(
    parameter int unsigned CNT_W = 9,
    parameter int unsigned RGB_W = 12
);
    logic [RGB_W-1:0] iRGB;
    logic [CNT_W-1:0] HPOS;
    logic [CNT_W-1:0] VPOS;
    logic [RGB_W-1:0] oRGB;
    logic             HBLK;
    logic             VBLK;
    logic             HSYN;
    logic             VSYN;
    logic             DE;
    logic             LINE_START;
    logic             FRAME_START;

    modport master (
        input  iRGB,
        output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_START, FRAME_START
    );

    modport slave (
        output iRGB,
        input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_START, FRAME_START
    );
endinterface

// File: rtl/vtg_axis_cnt.sv
// One raster axis: wrapping position counter with blank and sync window decode.
module vtg_axis_cnt #(
    parameter int unsigned CNT_W     = 9,
    parameter int unsigned TOTAL     = 384,
    parameter int unsigned ACTIVE    = 288,
    parameter int unsigned SYNC      = 32,
    parameter bit          LOOKAHEAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [CNT_W-1:0] sync_start,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_c,
    output logic             blank_c,
    output logic             sync_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] dec;
    logic             at_end;

    assign at_end  = (cnt_q == CNT_W'(TOTAL - 1));
    assign cnt_nxt = at_end ? '0 : cnt_q + CNT_W'(1);
    assign wrap_c  = adv && at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (adv) begin
            cnt_q <= cnt_nxt;
        end
    end

    // LOOKAHEAD decodes the position being entered so a caller can load it on the advancing edge.
    assign dec     = LOOKAHEAD ? cnt_nxt : cnt_q;
    assign sync_c  = (dec >= sync_start) && (dec <= sync_start + CNT_W'(SYNC - 1));
    assign blank_c = (cnt_q >= CNT_W'(ACTIVE));
    assign cnt     = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, registered blank/sync/DE/pixel outputs, line/frame pulses.
// Optional macro VTG_SCREEN_ADJ_EN adds per-frame H_ADJ/V_ADJ sync-position offsets.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned RGB_W    = DEF_RGB_W,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              PCLK_EN,
`ifdef VTG_SCREEN_ADJ_EN
    input  logic signed [3:0] H_ADJ,
    input  logic signed [3:0] V_ADJ,
`endif
    vtg_if.master             vid
);

    localparam int unsigned HTOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] hs_start;
    logic [CNT_W-1:0] vs_start;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             h_blank_c;
    logic             v_blank_c;
    logic             h_sync_c;
    logic             v_sync_c;
    int               h_off;
    int               v_off;

    logic             hblk_q;
    logic             vblk_q;
    logic             hsyn_q;
    logic             vsyn_q;
    logic             de_q;
    logic [RGB_W-1:0] orgb_q;

`ifdef VTG_SCREEN_ADJ_EN
    logic signed [3:0] h_adj_q;
    logic signed [3:0] v_adj_q;

    // Offsets only move at the frame boundary so sync never jumps mid-frame.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            h_adj_q <= '0;
            v_adj_q <= '0;
        end else if (v_wrap_c) begin
            h_adj_q <= H_ADJ;
            v_adj_q <= V_ADJ;
        end
    end

    assign h_off = 8 * int'(h_adj_q);
    assign v_off = int'(v_adj_q);
`else
    assign h_off = 0;
    assign v_off = 0;
`endif

    assign hs_start = CNT_W'(vtg_sync_start(H_ACTIVE, H_FP, H_SYNC, HTOTAL, h_off));
    assign vs_start = CNT_W'(vtg_sync_start(V_ACTIVE, V_FP, V_SYNC, VTOTAL, v_off));

    vtg_axis_cnt #(
        .CNT_W     (CNT_W),
        .TOTAL     (HTOTAL),
        .ACTIVE    (H_ACTIVE),
        .SYNC      (H_SYNC),
        .LOOKAHEAD (1'b0)
    ) u_h (
        .clk        (MCLK),
        .rst        (RESET),
        .adv        (PCLK_EN),
        .sync_start (hs_start),
        .cnt        (hcnt),
        .wrap_c     (h_wrap_c),
        .blank_c    (h_blank_c),
        .sync_c     (h_sync_c)
    );

    // Vertical sync decodes the line being entered so VSYN tracks VPOS on the line wrap.
    vtg_axis_cnt #(
        .CNT_W     (CNT_W),
        .TOTAL     (VTOTAL),
        .ACTIVE    (V_ACTIVE),
        .SYNC      (V_SYNC),
        .LOOKAHEAD (1'b1)
    ) u_v (
        .clk        (MCLK),
        .rst        (RESET),
        .adv        (h_wrap_c),
        .sync_start (vs_start),
        .cnt        (vcnt),
        .wrap_c     (v_wrap_c),
        .blank_c    (v_blank_c),
        .sync_c     (v_sync_c)
    );

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            hblk_q <= 1'b1;
            vblk_q <= 1'b1;
            de_q   <= 1'b0;
            orgb_q <= '0;
            hsyn_q <= ~HS_POL;
            vsyn_q <= ~VS_POL;
        end else if (PCLK_EN) begin
            hblk_q <= h_blank_c;
            vblk_q <= v_blank_c;
            de_q   <= ~(h_blank_c | v_blank_c);
            orgb_q <= (h_blank_c | v_blank_c) ? '0 : vid.iRGB;
            hsyn_q <= h_sync_c ? HS_POL : ~HS_POL;
            if (h_wrap_c) begin
                vsyn_q <= v_sync_c ? VS_POL : ~VS_POL;
            end
        end
    end

    assign vid.HPOS        = hcnt;
    assign vid.VPOS        = vcnt;
    assign vid.HBLK        = hblk_q;
    assign vid.VBLK        = vblk_q;
    assign vid.DE          = de_q;
    assign vid.oRGB        = orgb_q;
    assign vid.HSYN        = hsyn_q;
    assign vid.VSYN        = vsyn_q;
    assign vid.LINE_START  = h_wrap_c;
    assign vid.FRAME_START = v_wrap_c;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: default-geometry and small-geometry generators checked against a position-arithmetic model.
module tb_video_timing_gen;

    logic              MCLK;
    logic              RESET;
    logic              PCLK_EN;
    logic [11:0]       rgb;
    logic signed [3:0] H_ADJ;
    logic signed [3:0] V_ADJ;

    int checks = 0;
    int errors = 0;

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    vtg_if #(.CNT_W(9), .RGB_W(12)) vid0 ();
    vtg_if #(.CNT_W(9), .RGB_W(12)) vid1 ();

    video_timing_gen dut0 (
        .MCLK    (MCLK),
        .RESET   (RESET),
        .PCLK_EN (PCLK_EN),
`ifdef VTG_SCREEN_ADJ_EN
        .H_ADJ   (H_ADJ),
        .V_ADJ   (V_ADJ),
`endif
        .vid     (vid0)
    );

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (4), .H_BP (8),
        .V_ACTIVE (10), .V_FP (3), .V_SYNC (2), .V_BP (5),
        .CNT_W    (9),  .RGB_W (12), .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut1 (
        .MCLK    (MCLK),
        .RESET   (RESET),
        .PCLK_EN (PCLK_EN),
`ifdef VTG_SCREEN_ADJ_EN
        .H_ADJ   (H_ADJ),
        .V_ADJ   (V_ADJ),
`endif
        .vid     (vid1)
    );

    // Geometry per DUT: index 0 = defaults, index 1 = small raster.
    int g_ha[2]  = '{288, 16};
    int g_hfp[2] = '{22, 4};
    int g_hs[2]  = '{32, 4};
    int g_hbp[2] = '{42, 8};
    int g_va[2]  = '{224, 10};
    int g_vfp[2] = '{3, 3};
    int g_vs[2]  = '{7, 2};
    int g_vbp[2] = '{29, 5};

    // Model: k = enables since reset; position follows from plain division.
    int         k[2];
    int         sh_h[2];
    int         sh_v[2];
    logic       e_hblk[2];
    logic       e_vblk[2];
    logic       e_de[2];
    logic       e_hsyn[2];
    logic [11:0] e_rgb[2];

    int fs_cnt;
    int de_cnt;
    bit fs_seen;

    function automatic int ht(input int d);
        return g_ha[d] + g_hfp[d] + g_hs[d] + g_hbp[d];
    endfunction

    function automatic int vt(input int d);
        return g_va[d] + g_vfp[d] + g_vs[d] + g_vbp[d];
    endfunction

    function automatic int hpos(input int d);
        return k[d] % ht(d);
    endfunction

    function automatic int vpos(input int d);
        return (k[d] / ht(d)) % vt(d);
    endfunction

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            k[d]      = 0;
            sh_h[d]   = 0;
            sh_v[d]   = 0;
            e_hblk[d] = 1'b1;
            e_vblk[d] = 1'b1;
            e_de[d]   = 1'b0;
            e_hsyn[d] = 1'b1;
            e_rgb[d]  = '0;
        end
        fs_cnt  = 0;
        de_cnt  = 0;
        fs_seen = 1'b0;
    endtask

    task automatic model_step(input int d);
        int h, v, hss;
        h   = hpos(d);
        v   = vpos(d);
        hss = clampi(g_ha[d] + g_hfp[d] + 8 * sh_h[d], g_ha[d], ht(d) - g_hs[d]);
        e_hblk[d] = (h >= g_ha[d]);
        e_vblk[d] = (v >= g_va[d]);
        e_de[d]   = !(e_hblk[d] || e_vblk[d]);
        e_rgb[d]  = e_de[d] ? rgb : 12'h000;
        e_hsyn[d] = (h >= hss && h < hss + g_hs[d]) ? 1'b0 : 1'b1;
        if (h == ht(d) - 1 && v == vt(d) - 1) begin
            sh_h[d] = int'(H_ADJ);
            sh_v[d] = int'(V_ADJ);
        end
        k[d]++;
    endtask

    task automatic check_dut(input int d, input logic [8:0] hp, input logic [8:0] vp,
                             input logic [11:0] orgb, input logic hb, input logic vb,
                             input logic hs, input logic vs, input logic de,
                             input logic ls, input logic fs);
        int  h, v, vss;
        bit  act;
        h   = hpos(d);
        v   = vpos(d);
        vss = clampi(g_va[d] + g_vfp[d] + sh_v[d], g_va[d], vt(d) - g_vs[d]);
        act = PCLK_EN && !RESET;
        chk(d, "hpos", 32'(hp), 32'(h));
        chk(d, "vpos", 32'(vp), 32'(v));
        chk(d, "hblk", 32'(hb), 32'(e_hblk[d]));
        chk(d, "vblk", 32'(vb), 32'(e_vblk[d]));
        chk(d, "de", 32'(de), 32'(e_de[d]));
        chk(d, "orgb", 32'(orgb), 32'(e_rgb[d]));
        chk(d, "hsyn", 32'(hs), 32'(e_hsyn[d]));
        chk(d, "vsyn", 32'(vs), (v >= vss && v < vss + g_vs[d]) ? 32'd0 : 32'd1);
        chk(d, "line_start", 32'(ls), 32'(act && h == ht(d) - 1));
        chk(d, "frame_start", 32'(fs), 32'(act && h == ht(d) - 1 && v == vt(d) - 1));
    endtask

    // One MCLK: drive at negedge, check before the edge, advance the model on enabled edges.
    task automatic tick(input logic en, input logic rst);
        @(negedge MCLK);
        PCLK_EN   = en;
        RESET     = rst;
        rgb       = 12'($urandom);
        vid0.iRGB = rgb;
        vid1.iRGB = rgb;
        #1;
        if (rst) model_reset();
        check_dut(0, vid0.HPOS, vid0.VPOS, vid0.oRGB, vid0.HBLK, vid0.VBLK, vid0.HSYN,
                  vid0.VSYN, vid0.DE, vid0.LINE_START, vid0.FRAME_START);
        check_dut(1, vid1.HPOS, vid1.VPOS, vid1.oRGB, vid1.HBLK, vid1.VBLK, vid1.HSYN,
                  vid1.VSYN, vid1.DE, vid1.LINE_START, vid1.FRAME_START);
        if (en && !rst) begin
            fs_cnt++;
            if (vid1.DE) de_cnt++;
            if (vid1.FRAME_START) begin
                if (fs_seen) begin
                    chk(1, "frame_len", 32'(fs_cnt), 32'(ht(1) * vt(1)));
                    chk(1, "de_per_frame", 32'(de_cnt), 32'(g_ha[1] * g_va[1]));
                end
                fs_cnt  = 0;
                de_cnt  = 0;
                fs_seen = 1'b1;
            end
        end
        @(posedge MCLK);
        if (en && !rst) begin
            model_step(0);
            model_step(1);
        end
        #1;
    endtask

    initial begin
        PCLK_EN   = 1'b0;
        RESET     = 1'b1;
        rgb       = '0;
        H_ADJ     = '0;
        V_ADJ     = '0;
        vid0.iRGB = '0;
        vid1.iRGB = '0;
        model_reset();

        repeat (3) tick(1'b1, 1'b1);
        repeat (900) tick(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) tick(1'((i % 4) == 3), 1'b0);
        repeat (50) tick(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 1)), 1'b0);

        // Reset in the middle of a default-geometry line, then release with the enable high.
        for (int i = 0; i < 400; i++) begin
            if (hpos(0) == 150) break;
            tick(1'b1, 1'b0);
        end
        chk(0, "pre_reset_hpos", 32'(vid0.HPOS), 32'd150);
        repeat (2) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk(0, "post_reset_hpos", 32'(vid0.HPOS), 32'd1);
        chk(0, "post_reset_de", 32'(vid0.DE), 32'd1);
        repeat (200) tick(1'b1, 1'b0);

`ifdef VTG_SCREEN_ADJ_EN
        H_ADJ = 4'sd7;
        V_ADJ = -4'sd8;
        for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        H_ADJ = -4'sd8;
        V_ADJ = 4'sd7;
        for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        H_ADJ = 4'sd3;
        V_ADJ = -4'sd2;
        repeat (1400) tick(1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
